// File: rtl/core_ctrl_seq_if.sv
// Instruction fetch channel between core_ctrl_seq and the instruction memory.
// master: sequencer side (drives request and address)
// slave : memory side (returns valid and instruction word)
interface core_ctrl_seq_if #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 6
);
    logic                instr_req;
    logic [PC_WIDTH-1:0] pc;
    logic                instr_valid;
    logic [WIDTH-1:0]    instr_data;

    modport master (
        output instr_req,
        output pc,
        input  instr_valid,
        input  instr_data
    );

    modport slave (
        input  instr_req,
        input  pc,
        output instr_valid,
        output instr_data
    );
endinterface

// File: rtl/core_ctrl_seq.sv
// core_ctrl_seq: per-core instruction sequencer.
// Fetches 8-bit instructions, decodes them, and drives the one-hot ALU
// opcode, operand bus select and accumulator write strobe.
// Optional feature: define CORE_CTRL_TRAP_EN to trap illegal opcodes into
// HALT with a sticky illegal flag; otherwise illegal opcodes act as NOP.
module core_ctrl_seq #(
    parameter int WIDTH      = 8,
    parameter int PC_WIDTH   = 6,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    core_ctrl_seq_if.master      fetch,
    output logic [3:0]           alu_op,
    output logic [3:0]           bus_sel,
    output logic                 ac_we,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [WIDTH-1:0]    r_instr;
    logic [3:0]          r_op;
    logic [3:0]          r_cnt;
    logic [3:0]          w_opc;
    logic [3:0]          w_op_dec;
    logic                w_req;
    logic [3:0]          w_alu;
    logic [3:0]          w_bus;
    logic                w_we;
    logic                w_busy;
    logic                w_halted;
`ifdef CORE_CTRL_TRAP_EN
    logic                r_illegal;
    logic                w_trap;
`endif

    assign w_opc = r_instr[7:4];

    // Opcode to one-hot ALU operation; zero for anything that does not execute
    always_comb begin
        w_op_dec = 4'b0000;
        case (w_opc)
            4'h1:    w_op_dec = 4'b0001;
            4'h2:    w_op_dec = 4'b0010;
            4'h3:    w_op_dec = 4'b0100;
            4'h4:    w_op_dec = 4'b1000;
            default: w_op_dec = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_alu    = 4'b0000;
        w_bus    = 4'b0000;
        w_we     = 1'b0;
        w_busy   = 1'b0;
        w_halted = 1'b0;
`ifdef CORE_CTRL_TRAP_EN
        w_trap   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                if (fetch.instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_busy = 1'b1;
                if (w_opc == 4'h0) begin
                    w_next = S_FETCH;
                end else if (w_op_dec != 4'b0000) begin
                    w_next = S_EXEC;
                end else if (w_opc == 4'hF) begin
                    w_next = S_HALT;
                end else begin
`ifdef CORE_CTRL_TRAP_EN
                    w_trap = 1'b1;
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                w_busy = 1'b1;
                w_alu  = r_op;
                w_bus  = r_instr[3:0];
                if (r_cnt == 4'd1) begin
                    w_we   = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (start) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Program counter, instruction latch, decoded op and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) r_pc <= '0;
                end
                S_FETCH: begin
                    if (fetch.instr_valid) begin
                        r_instr <= fetch.instr_data;
                        r_pc    <= r_pc + PC_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    r_op  <= w_op_dec;
                    r_cnt <= (w_opc == 4'h2) ? 4'(MUL_CYCLES) : 4'd1;
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CORE_CTRL_TRAP_EN
    // Sticky illegal flag: set on trap, cleared by reset or restart from HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_trap) begin
            r_illegal <= 1'b1;
        end else if (r_state == S_HALT && start) begin
            r_illegal <= 1'b0;
        end
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign fetch.instr_req = w_req;
    assign fetch.pc        = r_pc;
    assign alu_op          = w_alu;
    assign bus_sel         = w_bus;
    assign ac_we           = w_we;
    assign busy            = w_busy;
    assign halted          = w_halted;

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Self-checking bench for core_ctrl_seq: directed scenarios plus random
// programs with random fetch wait states, checked cycle by cycle against an
// instruction-level timing model.
module tb_core_ctrl_seq;

    localparam int MUL_CYC = 3;
`ifdef CORE_CTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;
    logic [3:0] alu_op, bus_sel, alu_op2, bus_sel2;
    logic ac_we, busy, halted, illegal;
    logic ac_we2, busy2, halted2, illegal2;

    core_ctrl_seq_if #(.WIDTH(8), .PC_WIDTH(6)) ifc ();
    core_ctrl_seq_if #(.WIDTH(8), .PC_WIDTH(2)) ifc2 ();

    core_ctrl_seq #(.WIDTH(8), .PC_WIDTH(6), .MUL_CYCLES(MUL_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .fetch(ifc.master),
        .alu_op(alu_op), .bus_sel(bus_sel), .ac_we(ac_we), .busy(busy),
        .halted(halted), .illegal(illegal)
    );

    core_ctrl_seq #(.WIDTH(8), .PC_WIDTH(2), .MUL_CYCLES(MUL_CYC)) dut_w (
        .clk(clk), .rst(rst), .start(start2), .fetch(ifc2.master),
        .alu_op(alu_op2), .bus_sel(bus_sel2), .ac_we(ac_we2), .busy(busy2),
        .halted(halted2), .illegal(illegal2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [5:0] pc;
        logic       chk_pc;
        logic [3:0] op;
        logic [3:0] bus;
        logic       we;
        logic       busy;
        logic       halted;
        logic       ill;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] prog[64];
    int         waits[64];
    int         we_cyc[$];
    logic [3:0] we_op[$];
    int         n_mul;
    int         n_req0;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic rec_t mk(logic req, int pc, logic chk, logic [3:0] op,
                                logic [3:0] bus, logic we, logic bsy,
                                logic hlt, logic ill);
        rec_t r;
        r.req = req; r.pc = 6'(pc); r.chk_pc = chk; r.op = op; r.bus = bus;
        r.we = we; r.busy = bsy; r.halted = hlt; r.ill = ill;
        return r;
    endfunction

    // Expected per-cycle trace from the first FETCH cycle through HALT
    function automatic void build_expect(input int n);
        logic [3:0] opc;
        int cyc;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            opc = prog[k][7:4];
            for (int w = 0; w <= waits[k]; w++)
                exp_q.push_back(mk(1'b1, k, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, 0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
            if (opc >= 4'h1 && opc <= 4'h4) begin
                cyc = (opc == 4'h2) ? MUL_CYC : 1;
                for (int c = 0; c < cyc; c++)
                    exp_q.push_back(mk(1'b0, 0, 1'b0, 4'(1 << (opc - 1)), prog[k][3:0],
                                       c == cyc - 1, 1'b1, 1'b0, 1'b0));
            end else if (opc == 4'hF) begin
                exp_q.push_back(mk(1'b0, k + 1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
                return;
            end else if (opc != 4'h0 && TRAP) begin
                exp_q.push_back(mk(1'b0, k + 1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));
                return;
            end
        end
    endfunction

    // Start the DUT from IDLE/HALT and check every cycle of program execution
    task automatic run_prog(input int n);
        rec_t e;
        int wl, fidx;
        logic [8:0] obs, expv;
        build_expect(n);
        we_cyc.delete();
        we_op.delete();
        n_mul = 0;
        n_req0 = 0;
        fidx = 0;
        wl = waits[0];
        @(negedge clk);
        start = 1'b1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            obs  = {ifc.instr_req, alu_op, ac_we, busy, halted, illegal};
            expv = {e.req, e.op, e.we, e.busy, e.halted, e.ill};
            n_cmp++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL ctrl cyc=%0d req/op/we/busy/halt/ill got %b expected %b", i + 1, obs, expv);
            end
            if (e.chk_pc) begin
                n_cmp++;
                if (ifc.pc !== e.pc) begin
                    n_err++;
                    $display("FAIL pc cyc=%0d got %0d expected %0d", i + 1, ifc.pc, e.pc);
                end
            end
            if (e.op != 4'h0) begin
                n_cmp++;
                if (bus_sel !== e.bus) begin
                    n_err++;
                    $display("FAIL bus_sel cyc=%0d got %h expected %h", i + 1, bus_sel, e.bus);
                end
            end
            if (ac_we) begin
                we_cyc.push_back(i + 1);
                we_op.push_back(alu_op);
            end
            if (alu_op == 4'b0010) n_mul++;
            if (ifc.instr_req && ifc.pc == 6'd0) n_req0++;
            // memory responder; noise on valid/data outside FETCH must be ignored
            if (ifc.instr_req) begin
                if (wl > 0) begin
                    ifc.instr_valid = 1'b0;
                    ifc.instr_data  = 8'($urandom);
                    wl--;
                end else begin
                    ifc.instr_valid = 1'b1;
                    ifc.instr_data  = prog[ifc.pc];
                    fidx++;
                end
            end else begin
                ifc.instr_valid = 1'($urandom_range(0, 1));
                ifc.instr_data  = 8'($urandom);
                wl = (fidx < 64) ? waits[fidx] : 0;
            end
            start = e.busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        ifc.instr_valid = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            prog[i] = 8'hF0;
            waits[i] = 0;
        end
    endtask

    task automatic test_reset();
        logic [22:0] o1;
        logic [16:0] o2;
        rst = 1'b1;
        start = 1'b1;
        start2 = 1'b1;
        ifc.instr_valid = 1'b1;
        ifc.instr_data = 8'h12;
        ifc2.instr_valid = 1'b1;
        ifc2.instr_data = 8'h00;
        repeat (3) @(negedge clk);
        o1 = {alu_op, bus_sel, ac_we, busy, halted, illegal, ifc.instr_req, ifc.pc};
        o2 = {alu_op2, bus_sel2, ac_we2, busy2, halted2, illegal2, ifc2.instr_req, ifc2.pc};
        n_cmp++;
        if (o1 !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h expected 0", o1);
        end
        n_cmp++;
        if (o2 !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs_w got %h expected 0", o2);
        end
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, ifc.instr_req} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle_hold got %b expected 00", {busy, ifc.instr_req});
        end
    endtask

    task automatic test_program();
        clear_prog();
        prog[0] = 8'h12; prog[1] = 8'h33; prog[2] = 8'hF0;
        run_prog(3);
        n_cmp++;
        if (we_cyc.size() != 2 || we_cyc[0] != 3 || we_cyc[1] != 6) begin
            n_err++;
            $display("FAIL prog_we_cycles got %p expected 3 and 6", we_cyc);
        end
        n_cmp++;
        if (we_op.size() != 2 || we_op[0] !== 4'b0001 || we_op[1] !== 4'b0100) begin
            n_err++;
            $display("FAIL prog_we_ops got %p expected 0001 then 0100", we_op);
        end
        n_cmp++;
        if ({halted, ifc.pc} !== {1'b1, 6'd3}) begin
            n_err++;
            $display("FAIL prog_halt halted=%b pc=%0d expected halted=1 pc=3", halted, ifc.pc);
        end
    endtask

    task automatic test_mul();
        clear_prog();
        prog[0] = 8'h25; prog[1] = 8'hF0;
        run_prog(2);
        n_cmp++;
        if (n_mul != 3) begin
            n_err++;
            $display("FAIL mul_len got %0d expected 3", n_mul);
        end
        n_cmp++;
        if (we_cyc.size() != 1 || we_cyc[0] != 5) begin
            n_err++;
            $display("FAIL mul_we got %p expected single pulse at 5", we_cyc);
        end
    endtask

    task automatic test_fetch_wait();
        clear_prog();
        prog[0] = 8'h12; prog[1] = 8'hF0;
        waits[0] = 4;
        run_prog(2);
        n_cmp++;
        if (n_req0 != 5) begin
            n_err++;
            $display("FAIL wait_pc_hold got %0d req cycles at pc0 expected 5", n_req0);
        end
        n_cmp++;
        if (we_cyc.size() != 1 || we_cyc[0] != 7) begin
            n_err++;
            $display("FAIL wait_we got %p expected single pulse at 7", we_cyc);
        end
    endtask

    task automatic test_illegal();
        clear_prog();
        prog[0] = 8'h70; prog[1] = 8'h11; prog[2] = 8'hF0;
        run_prog(3);
`ifdef CORE_CTRL_TRAP_EN
        n_cmp++;
        if ({illegal, halted, ifc.pc} !== {1'b1, 1'b1, 6'd1} || we_cyc.size() != 0) begin
            n_err++;
            $display("FAIL illegal_trap ill=%b halted=%b pc=%0d we=%0d expected 1 1 1 0",
                     illegal, halted, ifc.pc, we_cyc.size());
        end
`else
        n_cmp++;
        if (we_cyc.size() != 1 || we_cyc[0] != 5 || we_op[0] !== 4'b0001 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_nop we=%p ill=%b expected SET pulse at 5 and ill=0", we_cyc, illegal);
        end
`endif
    endtask

    task automatic test_random();
        int n, r;
        for (int t = 0; t < 40; t++) begin
            clear_prog();
            n = $urandom_range(2, 14);
            for (int k = 0; k < n - 1; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      prog[k] = {4'h0, 4'($urandom)};
                else if (r == 1) prog[k] = {4'($urandom_range(5, 14)), 4'($urandom)};
                else             prog[k] = {4'($urandom_range(1, 4)), 4'($urandom)};
                waits[k] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            end
            prog[n - 1] = {4'hF, 4'($urandom)};
            waits[n - 1] = $urandom_range(0, 2);
            run_prog(n);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [22:0] o1;
        clear_prog();
        prog[0] = 8'h25; prog[1] = 8'hF0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            ifc.instr_valid = ifc.instr_req;
            ifc.instr_data  = prog[ifc.pc];
            if (c < 4) @(negedge clk);
        end
        n_cmp++;
        if ({alu_op, ac_we} !== {4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL mid_exec_pre got op=%b we=%b expected 0010 0", alu_op, ac_we);
        end
        rst = 1'b1;
        @(negedge clk);
        o1 = {alu_op, bus_sel, ac_we, busy, halted, illegal, ifc.instr_req, ifc.pc};
        n_cmp++;
        if (o1 !== 23'd0) begin
            n_err++;
            $display("FAIL mid_exec_reset got %h expected 0", o1);
        end
        rst = 1'b0;
        start = 1'b1;
        ifc.instr_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({ac_we, ifc.instr_req, ifc.pc} !== {1'b0, 1'b1, 6'd0}) begin
            n_err++;
            $display("FAIL mid_exec_restart we=%b req=%b pc=%0d expected 0 1 0", ac_we, ifc.instr_req, ifc.pc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pc_wrap();
        int pcs[$];
        int exp_pc[6] = '{0, 1, 2, 3, 0, 1};
        ifc2.instr_valid = 1'b1;
        ifc2.instr_data  = 8'h00;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            n_cmp++;
            if (busy2 !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_busy cyc=%0d got %b expected 1", c, busy2);
            end
            if (ifc2.instr_req) pcs.push_back(int'(ifc2.pc));
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= pcs.size() || pcs[i] != exp_pc[i]) begin
                n_err++;
                $display("FAIL wrap_pc idx=%0d got %0d expected %0d", i,
                         (i < pcs.size()) ? pcs[i] : -1, exp_pc[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.instr_data = 8'h00;
        ifc2.instr_valid = 1'b0;
        ifc2.instr_data = 8'h00;
        test_reset();
        test_program();
        test_mul();
        test_fetch_wait();
        test_illegal();
        test_random();
        test_reset_mid_exec();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_ctrl_seq.md
# core_ctrl_seq

Per-core instruction sequencer that drives the one-hot ALU opcode and the accumulator write strobe.
- Fetches 8-bit instructions over a valid/ready handshake and decodes them.
- Sequences each instruction through a fixed multi-cycle state machine, stretching MUL by a configurable stall count.
- Sits between the instruction memory and each core's ALU/accumulator datapath in the multi-core build; it is the producer of the ALU's operation and bus controls.

## Interface
- WIDTH, 8, instruction word width (opcode [7:4], operand [3:0]).
- PC_WIDTH, 6, program counter width.
- MUL_CYCLES, 3, EXECUTE cycles for MUL (1..15).

- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins execution at pc=0 from IDLE or HALT.
- instr_req  output  1  fetch request to instruction memory.
- pc  output  PC_WIDTH  fetch address, valid while instr_req=1.
- instr_valid  input  1  instruction memory response valid.
- instr_data  input  WIDTH  instruction word.
- alu_op  output  4  one-hot: 0001 SET, 0010 MUL, 0100 ADD, 1000 ADDMEM; 0000 = hold AC.
- bus_sel  output  4  operand field of current instruction (register/bus source index).
- ac_we  output  1  accumulator write strobe, one cycle.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  high in HALT.
- illegal  output  1  sticky illegal-opcode flag (only with trap feature).

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: all outputs 0. start=1 -> pc<=0, FETCH.
- FETCH: instr_req=1, pc driven. instr_valid=1 is the accept: latch instr_data, pc<=pc+1, go DECODE. Otherwise stay in FETCH, with pc and instr_req held.
- DECODE opcodes:
  - 0x0 NOP -> FETCH, no ac_we.
  - 0x1 SET, 0x2 MUL, 0x3 ADD, 0x4 ADDMEM -> EXEC; load the stall counter.
  - 0xF HALT -> HALT.
  - Any other opcode is illegal; see Configuration.
- EXEC:
  - alu_op is held at the decoded one-hot value and bus_sel = instr[3:0].
  - The stall counter decrements each cycle. ac_we=1 in the final EXEC cycle; next state is FETCH.
- HALT: halted=1. start=1 -> pc<=0, illegal cleared, FETCH.
- alu_op=0000 and ac_we=0 in every state except EXEC.
- pc wraps modulo 2^PC_WIDTH; 63+1 -> 0 at default width.
- start is ignored while busy=1.
- rst=1 in any state forces IDLE next cycle and clears pc, alu_op, bus_sel, ac_we, instr_req, busy, halted and illegal, including mid-EXEC. A pending fetch is abandoned.

## Timing
- Reset values: every output is 0.
- Per-instruction cycles, with zero-wait memory:
  - SET/ADD/ADDMEM: 3 (FETCH, DECODE, EXEC).
  - MUL: 2+MUL_CYCLES.
  - NOP: 2.
- Each cycle instr_valid is low in FETCH adds exactly one cycle.
- ac_we asserts in the same cycle as the last cycle alu_op is non-zero. The accumulator captures the ALU result on the following clk edge.
- instr_data is sampled only when instr_req=1 and instr_valid=1. instr_valid outside FETCH is ignored.
- start coincident with rst: rst wins.

## Configuration
- CORE_CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE sets illegal=1 and goes to HALT, with no ac_we.
  - illegal stays high until rst or a restarting start.
- CORE_CTRL_TRAP_EN undefined:
  - An illegal opcode is executed as NOP (DECODE -> FETCH).
  - illegal is tied to 0.

## Test plan
- Reset then start. Program {0x12, 0x33, 0xF0}, zero-wait memory.
  - Required: alu_op=0001 with bus_sel=2, then alu_op=0100 with bus_sel=3. ac_we pulses at cycles 3 and 6 after start.
  - Then halted=1 with pc=3.
- MUL timing. Program {0x25, 0xF0}, MUL_CYCLES=3.
  - Required: alu_op=0010 for exactly 3 consecutive cycles; ac_we only in the 3rd.
- Fetch wait states. instr_valid held low 4 cycles in FETCH.
  - Required: pc and instr_req stable throughout; the instruction completes 4 cycles later than the zero-wait case.
- Illegal opcode 0x70 followed by 0x11.
  - With CORE_CTRL_TRAP_EN: illegal=1, halted=1, no ac_we.
  - Without it: the 0x70 is treated as NOP, and 0x11 executes (alu_op=0001 with ac_we).
- Reset mid-EXEC of MUL (cycle 2 of 3), then start.
  - Required: all outputs 0 next cycle and no ac_we. After start, fetch resumes at pc=0.
- PC wrap, PC_WIDTH=2. Program of four NOPs, memory returning NOP continuously.
  - Required: pc sequence 0, 1, 2, 3, 0, 1; busy stays 1.
